// File: rtl/rv_sched_pkg.sv
// Shared types and helpers for the ALU wakeup tracker.
// Contents:
//   NCOMMIT/LNCOMMIT/NALLOC/NWB : slot count, index width, alloc ports, writeback ports
//   unit_t                      : execution class a slot is steered to
//   wakeup_slot_t               : per-slot tracked state
//   wb_tag_hit()                : does a tag match any valid writeback broadcast
//   popcount()                  : count set bits of a slot-wide vector
package rv_sched_pkg;

  localparam int NCOMMIT  = 32;
  localparam int LNCOMMIT = 5;
  localparam int NALLOC   = 4;
  localparam int NWB      = 4;

  typedef enum logic [1:0] {
    U_ALU   = 2'd0,
    U_SHIFT = 2'd1,
    U_MUL   = 2'd2,
    U_BR    = 2'd3
  } unit_t;

  typedef struct packed {
    logic                valid;
    unit_t               unit;
    logic                s1_rdy;
    logic [LNCOMMIT-1:0] s1_tag;
    logic                s2_rdy;
    logic [LNCOMMIT-1:0] s2_tag;
  } wakeup_slot_t;

  function automatic logic wb_tag_hit(input logic [NWB-1:0]          wb_valid,
                                      input logic [NWB*LNCOMMIT-1:0] wb_tag,
                                      input logic [LNCOMMIT-1:0]     tag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < NWB; w++) begin
      if (wb_valid[w] && (wb_tag[w*LNCOMMIT +: LNCOMMIT] == tag)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  function automatic logic [LNCOMMIT:0] popcount(input logic [NCOMMIT-1:0] v);
    logic [LNCOMMIT:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      cnt = cnt + {{LNCOMMIT{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/alu_wakeup_chk.sv
// Protocol checker for alu_wakeup (simulation only).
// Flags an allocation onto a live slot that is not being cleared in the same cycle.
// Ports: clk, reset, per-slot alloc strobe, valid state and clear mask.
module alu_wakeup_chk
  import rv_sched_pkg::*;
(
  input logic               clk,
  input logic               reset,
  input logic [NCOMMIT-1:0] alloc_hit_i,
  input logic [NCOMMIT-1:0] valid_i,
  input logic [NCOMMIT-1:0] clr_i
);

  ap_no_live_overwrite: assert property (@(posedge clk) disable iff (!reset)
    ((alloc_hit_i & valid_i & ~clr_i) == {NCOMMIT{1'b0}}));

endmodule

// File: rtl/wakeup_slot.sv
// One commit slot of the wakeup tracker.
// Holds valid/unit/source state, snoops the writeback tag ports and reports
// whether both sources are ready.
// Optional feature: ALU_WAKEUP_BYPASS_EN makes ready_o also reflect
// writeback matches of the current cycle.
// Ports:
//   clk, reset        : clock, async active-low reset
//   alloc_i, alloc_*  : allocate this slot with the given unit/source info
//   clr_i             : kill or issue of the pre-existing entry
//   wb_valid_i/tag_i  : writeback tag broadcasts
//   valid_o, ready_o, unit_o : slot state for the top-level steering
module wakeup_slot
  import rv_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_i,
  input  logic [1:0]              alloc_unit_i,
  input  logic                    alloc_s1_rdy_i,
  input  logic [LNCOMMIT-1:0]     alloc_s1_tag_i,
  input  logic                    alloc_s2_rdy_i,
  input  logic [LNCOMMIT-1:0]     alloc_s2_tag_i,
  input  logic                    clr_i,
  input  logic [NWB-1:0]          wb_valid_i,
  input  logic [NWB*LNCOMMIT-1:0] wb_tag_i,
  output logic                    valid_o,
  output logic                    ready_o,
  output logic [1:0]              unit_o
);

  wakeup_slot_t slot_q;
  wakeup_slot_t slot_d;
  logic         s1_hit_s;
  logic         s2_hit_s;
  logic         a1_hit_s;
  logic         a2_hit_s;

  assign s1_hit_s = wb_tag_hit(wb_valid_i, wb_tag_i, slot_q.s1_tag);
  assign s2_hit_s = wb_tag_hit(wb_valid_i, wb_tag_i, slot_q.s2_tag);
  // A producer broadcasting in the allocation cycle would otherwise be missed
  assign a1_hit_s = wb_tag_hit(wb_valid_i, wb_tag_i, alloc_s1_tag_i);
  assign a2_hit_s = wb_tag_hit(wb_valid_i, wb_tag_i, alloc_s2_tag_i);

  // Next state: alloc replaces the entry, else clear, else accumulate wakeups
  always_comb begin
    slot_d = slot_q;
    if (alloc_i) begin
      slot_d.valid  = 1'b1;
      slot_d.unit   = unit_t'(alloc_unit_i);
      slot_d.s1_rdy = alloc_s1_rdy_i | a1_hit_s;
      slot_d.s1_tag = alloc_s1_tag_i;
      slot_d.s2_rdy = alloc_s2_rdy_i | a2_hit_s;
      slot_d.s2_tag = alloc_s2_tag_i;
    end else if (clr_i) begin
      slot_d.valid  = 1'b0;
      slot_d.s1_rdy = 1'b0;
      slot_d.s2_rdy = 1'b0;
    end else begin
      slot_d.s1_rdy = slot_q.s1_rdy | s1_hit_s;
      slot_d.s2_rdy = slot_q.s2_rdy | s2_hit_s;
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

`ifdef ALU_WAKEUP_BYPASS_EN
  // Same-cycle wakeup; issue/kill still only take effect from the next cycle
  assign ready_o = slot_q.valid & (slot_q.s1_rdy | s1_hit_s) & (slot_q.s2_rdy | s2_hit_s);
`else
  assign ready_o = slot_q.valid & slot_q.s1_rdy & slot_q.s2_rdy;
`endif

  assign valid_o = slot_q.valid;
  assign unit_o  = slot_q.unit;

endmodule

// File: rtl/alu_wakeup.sv
// Per-commit-slot operand wakeup tracker feeding the ALU scheduler.
// Slots are allocated with source tags, woken by writeback tag broadcasts,
// and cleared by issue or kill. Ready vectors per unit class are rotated
// so bit 0 corresponds to start_commit (oldest slot).
// Optional feature: ALU_WAKEUP_BYPASS_EN adds same-cycle writeback bypass
// to the ready outputs.
// Ports:
//   clk, reset                    : clock, async active-low reset
//   alloc_valid/idx/unit/s1_*/s2_*: NALLOC allocation ports
//   wb_valid, wb_tag              : NWB writeback broadcasts
//   issue_clr, kill               : absolute-indexed clear masks
//   start_commit                  : rotation base
//   alu/shift/mul/br_ready        : rotated ready vectors per unit class
//   occupancy                     : number of valid slots
module alu_wakeup
  import rv_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NALLOC-1:0]          alloc_valid,
  input  logic [NALLOC*LNCOMMIT-1:0] alloc_idx,
  input  logic [NALLOC*2-1:0]        alloc_unit,
  input  logic [NALLOC-1:0]          alloc_s1_rdy,
  input  logic [NALLOC*LNCOMMIT-1:0] alloc_s1_tag,
  input  logic [NALLOC-1:0]          alloc_s2_rdy,
  input  logic [NALLOC*LNCOMMIT-1:0] alloc_s2_tag,
  input  logic [NWB-1:0]             wb_valid,
  input  logic [NWB*LNCOMMIT-1:0]    wb_tag,
  input  logic [NCOMMIT-1:0]         issue_clr,
  input  logic [NCOMMIT-1:0]         kill,
  input  logic [LNCOMMIT-1:0]        start_commit,
  output logic [NCOMMIT-1:0]         alu_ready,
  output logic [NCOMMIT-1:0]         shift_ready,
  output logic [NCOMMIT-1:0]         mul_ready,
  output logic [NCOMMIT-1:0]         br_ready,
  output logic [LNCOMMIT:0]          occupancy
);

  wakeup_slot_t        alloc_ent_s [NCOMMIT];
  logic [NCOMMIT-1:0]  alloc_hit_s;
  logic [NCOMMIT-1:0]  clr_s;
  logic [NCOMMIT-1:0]  valid_s;
  logic [NCOMMIT-1:0]  ready_s;
  logic [1:0]          unit_s [NCOMMIT];
  logic [LNCOMMIT:0]   occ_q;
  logic [LNCOMMIT:0]   occ_d;
  logic [LNCOMMIT-1:0] rot_idx_s;

  assign clr_s = kill | issue_clr;

  // Alloc decode: ports scanned low to high so the highest port wins a duplicate index
  always_comb begin
    for (int s = 0; s < NCOMMIT; s++) begin
      alloc_ent_s[s] = '0;
    end
    for (int k = 0; k < NALLOC; k++) begin
      if (alloc_valid[k]) begin
        alloc_ent_s[alloc_idx[k*LNCOMMIT +: LNCOMMIT]] = '{
          valid:  1'b1,
          unit:   unit_t'(alloc_unit[k*2 +: 2]),
          s1_rdy: alloc_s1_rdy[k],
          s1_tag: alloc_s1_tag[k*LNCOMMIT +: LNCOMMIT],
          s2_rdy: alloc_s2_rdy[k],
          s2_tag: alloc_s2_tag[k*LNCOMMIT +: LNCOMMIT]
        };
      end else begin
        // idle port contributes nothing
      end
    end
  end

  for (genvar s = 0; s < NCOMMIT; s++) begin : g_slot
    assign alloc_hit_s[s] = alloc_ent_s[s].valid;

    wakeup_slot u_slot (
      .clk            (clk),
      .reset          (reset),
      .alloc_i        (alloc_ent_s[s].valid),
      .alloc_unit_i   (alloc_ent_s[s].unit),
      .alloc_s1_rdy_i (alloc_ent_s[s].s1_rdy),
      .alloc_s1_tag_i (alloc_ent_s[s].s1_tag),
      .alloc_s2_rdy_i (alloc_ent_s[s].s2_rdy),
      .alloc_s2_tag_i (alloc_ent_s[s].s2_tag),
      .clr_i          (clr_s[s]),
      .wb_valid_i     (wb_valid),
      .wb_tag_i       (wb_tag),
      .valid_o        (valid_s[s]),
      .ready_o        (ready_s[s]),
      .unit_o         (unit_s[s])
    );
  end

  // Occupancy: newly valid slots minus live slots cleared without re-alloc.
  // A cleared-and-reallocated slot stays valid, so it nets to zero.
  always_comb begin
    occ_d = occ_q + popcount(alloc_hit_s & ~valid_s)
                  - popcount(valid_s & clr_s & ~alloc_hit_s);
  end

  // Occupancy register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  // Unit steering and rotation so bit 0 is the oldest slot
  always_comb begin
    alu_ready   = '0;
    shift_ready = '0;
    mul_ready   = '0;
    br_ready    = '0;
    rot_idx_s   = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      rot_idx_s = start_commit + LNCOMMIT'(i);
      case (unit_s[rot_idx_s])
        U_ALU:   alu_ready[i]   = ready_s[rot_idx_s];
        U_SHIFT: shift_ready[i] = ready_s[rot_idx_s];
        U_MUL:   mul_ready[i]   = ready_s[rot_idx_s];
        U_BR:    br_ready[i]    = ready_s[rot_idx_s];
        default: alu_ready[i]   = 1'b0;
      endcase
    end
  end

  alu_wakeup_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .alloc_hit_i (alloc_hit_s),
    .valid_i     (valid_s),
    .clr_i       (clr_s)
  );

endmodule
